// File: rtl/execute_stage.sv
// execute_stage: RV32I execute stage. Forwards operands from the EX/MEM
// register and the writeback port, evaluates the ALU and branch condition,
// and captures the results in the EX/MEM register that feeds the memory stage.
module execute_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rd1,
  input  logic [31:0] ex_rd2,
  input  logic [31:0] ex_imm,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_funct7b5,
  input  logic [1:0]  ex_alu_op,
  input  logic        ex_alu_src,
  input  logic        ex_branch,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_reg_write,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        mem_valid,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic        mem_mem_to_reg,
  output logic        mem_reg_write,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_store_data,
  output logic [4:0]  mem_rd,
  output logic        branch_taken,
  output logic [31:0] branch_target
);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  localparam logic [1:0] ALU_LUI = 2'b11;

  // EX/MEM register state
  logic        valid_q, mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q;
  logic        taken_q;
  logic [31:0] result_q, store_q, target_q;
  logic [4:0]  rd_q;

  // Next-state values for the EX/MEM register
  logic        valid_d, mem_read_d, mem_write_d, mem_to_reg_d, reg_write_d;
  logic        taken_d;
  logic [31:0] result_d, store_d, target_d;
  logic [4:0]  rd_d;

  logic        [31:0] op_a, fwd_b, op_b, alu_res;
  logic signed [31:0] op_a_s, op_b_s, sra_res;
  logic        [4:0]  shamt;
  logic               lt_s, lt_u, br_cond, squash;

  // Operand forwarding: a live MEM result beats the WB port; x0 is never forwarded
  always_comb begin
    op_a = ex_rd1;
    if (valid_q && reg_write_q && (rd_q != 5'd0) && (rd_q == ex_rs1))
      op_a = result_q;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
      op_a = wb_data;

    fwd_b = ex_rd2;
    if (valid_q && reg_write_q && (rd_q != 5'd0) && (rd_q == ex_rs2))
      fwd_b = result_q;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
      fwd_b = wb_data;
  end

  assign op_b    = ex_alu_src ? ex_imm : fwd_b;
  assign op_a_s  = op_a;
  assign op_b_s  = op_b;
  assign shamt   = op_b[4:0];
  assign sra_res = op_a_s >>> shamt;
  assign lt_s    = op_a_s < op_b_s;
  assign lt_u    = op_a < op_b;

  // ALU evaluation selected by alu_op, with funct3/funct7b5 decode for R/I types
  always_comb begin
    alu_res = 32'd0;
    case (ex_alu_op)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_BR:  alu_res = op_a - op_b;
      ALU_LUI: alu_res = ex_imm;
      ALU_FN: begin
        case (ex_funct3)
          3'b000:  alu_res = (ex_funct7b5 && !ex_alu_src) ? (op_a - op_b) : (op_a + op_b);
          3'b001:  alu_res = op_a << shamt;
          3'b010:  alu_res = {31'd0, lt_s};
          3'b011:  alu_res = {31'd0, lt_u};
          3'b100:  alu_res = op_a ^ op_b;
          3'b101:  alu_res = ex_funct7b5 ? sra_res : (op_a >> shamt);
          3'b110:  alu_res = op_a | op_b;
          default: alu_res = op_a & op_b;
        endcase
      end
      default: alu_res = 32'd0;
    endcase
  end

  // Branch condition from funct3; reserved encodings never branch
  always_comb begin
    br_cond = 1'b0;
    case (ex_funct3)
      3'b000:  br_cond = (op_a == op_b);
      3'b001:  br_cond = (op_a != op_b);
      3'b100:  br_cond = lt_s;
      3'b101:  br_cond = !lt_s;
      3'b110:  br_cond = lt_u;
      3'b111:  br_cond = !lt_u;
      default: br_cond = 1'b0;
    endcase
  end

  // Next-state values; control bits are qualified by ex_valid so bubbles carry no side effects
  always_comb begin
    valid_d      = ex_valid;
    mem_read_d   = ex_mem_read   & ex_valid;
    mem_write_d  = ex_mem_write  & ex_valid;
    mem_to_reg_d = ex_mem_to_reg & ex_valid;
    reg_write_d  = ex_reg_write  & ex_valid;
    taken_d      = ex_valid & ex_branch & br_cond;
    target_d     = ex_pc + ex_imm;
    result_d     = alu_res;
    store_d      = fwd_b;
    rd_d         = ex_rd;
  end

  // A redirect leaving EX/MEM marks the instruction now in EX as wrong-path
  assign squash = flush | taken_q;

  // Control half of EX/MEM: squash beats stall, so a held branch cannot fire twice
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      taken_q      <= 1'b0;
    end else if (squash) begin
      valid_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      taken_q      <= 1'b0;
    end else if (!stall) begin
      valid_q      <= valid_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      taken_q      <= taken_d;
    end
  end

  // Data half of EX/MEM: contents after a squash are irrelevant, so it simply loads
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= 32'd0;
      store_q  <= 32'd0;
      target_q <= 32'd0;
      rd_q     <= 5'd0;
    end else if (squash || !stall) begin
      result_q <= result_d;
      store_q  <= store_d;
      target_q <= target_d;
      rd_q     <= rd_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign mem_mem_to_reg = mem_to_reg_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_alu_result = result_q;
  assign mem_store_data = store_q;
  assign mem_rd         = rd_q;
  assign branch_taken   = taken_q;
  assign branch_target  = target_q;

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: vector table, directed corner sequences and a
// randomized run against a behavioural model of the execute stage.
module tb_execute_stage;

  logic        clock, reset_n, stall, flush, ex_valid;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic [1:0]  ex_alu_op;
  logic        ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
  logic [31:0] mem_alu_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic        branch_taken;
  logic [31:0] branch_target;

  int checks = 0;
  int failures = 0;

  execute_stage dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_valid(mem_valid), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .mem_rd(mem_rd), .branch_taken(branch_taken), .branch_target(branch_target)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        src;
    logic        br;
    logic [31:0] a, b, imm, pc, res;
    logic        tk;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[19];

  // behavioural model of the EX/MEM register contents
  logic        m_valid, m_mr, m_mw, m_mtr, m_rw, m_bt, m_known;
  logic [4:0]  m_rd;
  logic [31:0] m_res, m_sd, m_tgt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    stall = 0; flush = 0; ex_valid = 0; ex_pc = 0; ex_rd1 = 0; ex_rd2 = 0; ex_imm = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_funct3 = 0; ex_funct7b5 = 0; ex_alu_op = 0;
    ex_alu_src = 0; ex_branch = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
    ex_reg_write = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, mem_valid}, 0);
    chk({tag, "_mr"}, {31'd0, mem_mem_read}, 0);
    chk({tag, "_mw"}, {31'd0, mem_mem_write}, 0);
    chk({tag, "_mtr"}, {31'd0, mem_mem_to_reg}, 0);
    chk({tag, "_rw"}, {31'd0, mem_reg_write}, 0);
    chk({tag, "_res"}, mem_alu_result, 0);
    chk({tag, "_sd"}, mem_store_data, 0);
    chk({tag, "_rd"}, {27'd0, mem_rd}, 0);
    chk({tag, "_bt"}, {31'd0, branch_taken}, 0);
    chk({tag, "_tgt"}, branch_target, 0);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                              input logic src, input logic br, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                              input logic [31:0] res, input logic tk, input logic [31:0] tgt);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.src = src; v.br = br; v.a = a; v.b = b;
    v.imm = imm; v.pc = pc; v.res = res; v.tk = tk; v.tgt = tgt;
    return v;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] v);
    if (rs != 0 && m_valid && m_rw && m_rd == rs) return m_res;
    if (rs != 0 && wb_we && wb_rd == rs) return wb_data;
    return v;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [2:0] f3,
                                          input logic f7, input logic src, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    int sh;
    sh = int'(b % 32);
    if (op == 2'd0) return a + b;
    if (op == 2'd3) return imm;
    if (op == 2'd1) return a - b;
    case (f3)
      3'd0: return (f7 && !src) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return (f7 && a[31]) ? ~((~a) >> sh) : (a >> sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_rw = 0; m_bt = 0; m_known = 1;
    m_rd = 0; m_res = 0; m_sd = 0; m_tgt = 0;
  endtask

  // advance the model by one clock edge using the inputs now applied
  task automatic model_step();
    logic [31:0] a, r2, b, res;
    logic tk;
    a  = ref_fwd(ex_rs1, ex_rd1);
    r2 = ref_fwd(ex_rs2, ex_rd2);
    b  = ex_alu_src ? ex_imm : r2;
    res = ref_alu(ex_alu_op, ex_funct3, ex_funct7b5, ex_alu_src, a, b, ex_imm);
    tk = ex_valid && ex_branch && ref_cond(ex_funct3, a, b);
    if (flush || m_bt) begin
      m_valid = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_rw = 0; m_bt = 0; m_known = 0;
    end else if (!stall) begin
      m_valid = ex_valid;
      m_mr = ex_mem_read && ex_valid;
      m_mw = ex_mem_write && ex_valid;
      m_mtr = ex_mem_to_reg && ex_valid;
      m_rw = ex_reg_write && ex_valid;
      m_bt = tk;
      m_rd = ex_rd; m_res = res; m_sd = r2; m_tgt = ex_pc + ex_imm; m_known = 1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 40));
      2: return 32'h8000_0000 | 32'($urandom_range(0, 40));
      default: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic rand_inputs();
    stall = ($urandom_range(0, 99) < 15);
    flush = ($urandom_range(0, 99) < 8);
    ex_valid = ($urandom_range(0, 99) < 80);
    ex_rs1 = 5'($urandom_range(0, 3));
    ex_rs2 = 5'($urandom_range(0, 3));
    ex_rd = 5'($urandom_range(0, 3));
    ex_rd1 = pick(); ex_rd2 = pick(); ex_imm = pick(); ex_pc = $urandom;
    ex_funct3 = 3'($urandom_range(0, 7));
    ex_funct7b5 = ($urandom_range(0, 1) == 1);
    ex_branch = ($urandom_range(0, 99) < 20);
    if (ex_branch) begin
      ex_alu_op = 2'd1; ex_alu_src = 0; ex_reg_write = 0;
      ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
    end else begin
      ex_alu_op = 2'($urandom_range(0, 3));
      ex_alu_src = ($urandom_range(0, 1) == 1);
      ex_reg_write = ($urandom_range(0, 99) < 70);
      ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_mem_write = ($urandom_range(0, 3) == 0);
      ex_mem_to_reg = ($urandom_range(0, 3) == 0);
    end
    wb_we = ($urandom_range(0, 1) == 1);
    wb_rd = 5'($urandom_range(0, 3));
    wb_data = pick();
  endtask

  initial begin
    // vector table: single instructions with no forwarding
    vecs[0]  = mk(2'd0, 3'd0, 0, 1, 0, 32'd5, 32'd0, 32'd10, 0, 32'd15, 0, 0);
    vecs[1]  = mk(2'd3, 3'd0, 0, 1, 0, 32'hFFFF, 32'd0, 32'h1234_5000, 0, 32'h1234_5000, 0, 0);
    vecs[2]  = mk(2'd2, 3'd0, 1, 0, 0, 32'd10, 32'd3, 0, 0, 32'd7, 0, 0);
    vecs[3]  = mk(2'd2, 3'd0, 1, 1, 0, 32'd10, 32'h99, 32'd3, 0, 32'd13, 0, 0);
    vecs[4]  = mk(2'd2, 3'd1, 0, 0, 0, 32'd1, 32'h21, 0, 0, 32'd2, 0, 0);
    vecs[5]  = mk(2'd2, 3'd2, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd1, 0, 0);
    vecs[6]  = mk(2'd2, 3'd3, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd0, 0, 0);
    vecs[7]  = mk(2'd2, 3'd4, 0, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 32'hFF00_FF00, 0, 0);
    vecs[8]  = mk(2'd2, 3'd5, 1, 0, 0, 32'h8000_0010, 32'h24, 0, 0, 32'hF800_0001, 0, 0);
    vecs[9]  = mk(2'd2, 3'd5, 0, 0, 0, 32'h8000_0010, 32'h24, 0, 0, 32'h0800_0001, 0, 0);
    vecs[10] = mk(2'd2, 3'd6, 0, 0, 0, 32'hF0, 32'h0F, 0, 0, 32'hFF, 0, 0);
    vecs[11] = mk(2'd2, 3'd7, 0, 0, 0, 32'hF0, 32'h3C, 0, 0, 32'h30, 0, 0);
    vecs[12] = mk(2'd1, 3'd4, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 32'h100, 32'hFFFF_FFFE, 1, 32'hF0);
    vecs[13] = mk(2'd1, 3'd0, 0, 0, 1, 32'd1, 32'd2, 32'd8, 32'h200, 32'hFFFF_FFFF, 0, 32'h208);
    vecs[14] = mk(2'd1, 3'd7, 0, 0, 1, 32'h8000_0000, 32'd1, 32'h20, 32'hFFFF_FFF0, 32'h7FFF_FFFF, 1, 32'h10);
    vecs[15] = mk(2'd1, 3'd2, 0, 0, 1, 32'd1, 32'd1, 32'd4, 32'd0, 32'd0, 0, 32'd4);
    vecs[16] = mk(2'd1, 3'd5, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h10, 32'h40, 32'hFFFF_FFFF, 0, 32'h50);
    vecs[17] = mk(2'd1, 3'd6, 0, 0, 1, 32'd1, 32'hFFFF_FFFF, 32'hC, 32'd0, 32'd2, 1, 32'hC);
    vecs[18] = mk(2'd1, 3'd1, 0, 0, 1, 32'd5, 32'd5, 32'h10, 32'h10, 32'd0, 0, 32'h20);

    // reset state
    clr_in();
    reset_n = 0;
    ex_valid = 1; ex_reg_write = 1; ex_rd1 = 32'h55; ex_rd = 5'd3;
    #1;
    chk_zero("reset");
    @(negedge clock);
    reset_n = 1;
    model_reset();

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      model_step();
      tick();
      chk("rnd_valid", {31'd0, mem_valid}, {31'd0, m_valid});
      chk("rnd_mr", {31'd0, mem_mem_read}, {31'd0, m_mr});
      chk("rnd_mw", {31'd0, mem_mem_write}, {31'd0, m_mw});
      chk("rnd_mtr", {31'd0, mem_mem_to_reg}, {31'd0, m_mtr});
      chk("rnd_rw", {31'd0, mem_reg_write}, {31'd0, m_rw});
      chk("rnd_bt", {31'd0, branch_taken}, {31'd0, m_bt});
      if (m_known) begin
        chk("rnd_rd", {27'd0, mem_rd}, {27'd0, m_rd});
        chk("rnd_res", mem_alu_result, m_res);
        chk("rnd_sd", mem_store_data, m_sd);
        chk("rnd_tgt", branch_target, m_tgt);
      end
    end

    // clean restart for directed tests
    clr_in();
    reset_n = 0;
    #1;
    reset_n = 1;

    // table-driven vectors, each followed by an idle cycle
    for (int i = 0; i < 19; i++) begin
      clr_in();
      ex_valid = 1; ex_alu_op = vecs[i].op; ex_funct3 = vecs[i].f3; ex_funct7b5 = vecs[i].f7;
      ex_alu_src = vecs[i].src; ex_branch = vecs[i].br; ex_rd1 = vecs[i].a; ex_rd2 = vecs[i].b;
      ex_imm = vecs[i].imm; ex_pc = vecs[i].pc; ex_reg_write = !vecs[i].br; ex_rd = 5'd1;
      tick();
      chk($sformatf("vec%0d_res", i), mem_alu_result, vecs[i].res);
      chk($sformatf("vec%0d_valid", i), {31'd0, mem_valid}, 1);
      chk($sformatf("vec%0d_rw", i), {31'd0, mem_reg_write}, {31'd0, !vecs[i].br});
      chk($sformatf("vec%0d_bt", i), {31'd0, branch_taken}, {31'd0, vecs[i].tk});
      if (vecs[i].br) chk($sformatf("vec%0d_tgt", i), branch_target, vecs[i].tgt);
      clr_in();
      tick();
    end

    // MEM forwarding beats WB for a dependent sub
    clr_in();
    ex_valid = 1; ex_alu_src = 1; ex_rd1 = 32'd7; ex_rd = 5'd5; ex_reg_write = 1;
    tick();
    chk("fwdA_res", mem_alu_result, 32'd7);
    clr_in();
    ex_valid = 1; ex_alu_op = 2'd2; ex_funct7b5 = 1; ex_rs1 = 5'd5; ex_rd1 = 0;
    ex_rs2 = 5'd2; ex_rd2 = 32'd3; ex_rd = 5'd6; ex_reg_write = 1;
    wb_we = 1; wb_rd = 5'd5; wb_data = 32'd9;
    tick();
    chk("fwd_mem_sub", mem_alu_result, 32'd4);
    // WB forwarding on rs1, MEM forwarding into store data via rs2
    clr_in();
    ex_valid = 1; ex_alu_src = 1; ex_imm = 32'd1; ex_rs1 = 5'd7; ex_rs2 = 5'd6;
    ex_rd = 5'd8; ex_reg_write = 1; wb_we = 1; wb_rd = 5'd7; wb_data = 32'd100;
    tick();
    chk("fwd_wb_res", mem_alu_result, 32'd101);
    chk("fwd_mem_sd", mem_store_data, 32'd4);

    // taken blt squashes the next instruction, then flow resumes
    clr_in();
    ex_valid = 1; ex_branch = 1; ex_alu_op = 2'd1; ex_funct3 = 3'd4;
    ex_rd1 = 32'hFFFF_FFFF; ex_rd2 = 32'd1; ex_pc = 32'h100; ex_imm = 32'hFFFF_FFF0;
    tick();
    chk("blt_bt", {31'd0, branch_taken}, 1);
    chk("blt_tgt", branch_target, 32'hF0);
    clr_in();
    ex_valid = 1; ex_reg_write = 1; ex_rd = 5'd3;
    tick();
    chk("sq_valid", {31'd0, mem_valid}, 0);
    chk("sq_rw", {31'd0, mem_reg_write}, 0);
    chk("sq_bt", {31'd0, branch_taken}, 0);
    tick();
    chk("after_sq_valid", {31'd0, mem_valid}, 1);

    // stall holds everything for three cycles
    clr_in();
    ex_valid = 1; ex_alu_src = 1; ex_rd1 = 32'h55; ex_imm = 32'h22; ex_rd = 5'd9;
    ex_reg_write = 1; ex_mem_write = 1;
    tick();
    chk("pre_stall_res", mem_alu_result, 32'h77);
    stall = 1; ex_rd1 = 32'h1234; ex_rd = 5'd1; ex_mem_write = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_res", i), mem_alu_result, 32'h77);
      chk($sformatf("stall%0d_rd", i), {27'd0, mem_rd}, 32'd9);
      chk($sformatf("stall%0d_valid", i), {31'd0, mem_valid}, 1);
      chk($sformatf("stall%0d_mw", i), {31'd0, mem_mem_write}, 1);
      chk($sformatf("stall%0d_tgt", i), branch_target, 32'h22);
    end

    // a held taken branch cannot re-assert
    clr_in();
    ex_valid = 1; ex_branch = 1; ex_alu_op = 2'd1; ex_funct3 = 3'd1;
    ex_rd1 = 32'd1; ex_rd2 = 32'd2; ex_pc = 32'h400; ex_imm = 32'h8;
    tick();
    chk("hold_br_bt", {31'd0, branch_taken}, 1);
    stall = 1;
    tick();
    chk("hold_br_bt2", {31'd0, branch_taken}, 0);
    chk("hold_br_valid", {31'd0, mem_valid}, 0);

    // stall together with flush loads a bubble
    clr_in();
    ex_valid = 1; ex_reg_write = 1; ex_mem_write = 1; ex_mem_read = 1; ex_mem_to_reg = 1; ex_rd = 5'd4;
    tick();
    chk("pre_sf_valid", {31'd0, mem_valid}, 1);
    stall = 1; flush = 1;
    tick();
    chk("sf_valid", {31'd0, mem_valid}, 0);
    chk("sf_rw", {31'd0, mem_reg_write}, 0);
    chk("sf_mw", {31'd0, mem_mem_write}, 0);
    chk("sf_mr", {31'd0, mem_mem_read}, 0);
    chk("sf_mtr", {31'd0, mem_mem_to_reg}, 0);
    chk("sf_bt", {31'd0, branch_taken}, 0);

    // results for x0 never reach operands
    clr_in();
    ex_valid = 1; ex_alu_src = 1; ex_rd1 = 32'hDEAD; ex_rd = 5'd0; ex_reg_write = 1;
    tick();
    chk("x0A_res", mem_alu_result, 32'hDEAD);
    clr_in();
    ex_valid = 1; ex_alu_src = 1; ex_rs1 = 5'd0; ex_rd1 = 32'h11; ex_rd = 5'd2; ex_reg_write = 1;
    wb_we = 1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    tick();
    chk("x0_operand", mem_alu_result, 32'h11);

    // invalid entry carries no control side effects
    clr_in();
    ex_valid = 0; ex_reg_write = 1; ex_mem_read = 1; ex_mem_write = 1; ex_mem_to_reg = 1; ex_rd = 5'd3;
    tick();
    chk("inv_valid", {31'd0, mem_valid}, 0);
    chk("inv_rw", {31'd0, mem_reg_write}, 0);
    chk("inv_mr", {31'd0, mem_mem_read}, 0);
    chk("inv_mw", {31'd0, mem_mem_write}, 0);
    chk("inv_mtr", {31'd0, mem_mem_to_reg}, 0);

    // asynchronous reset mid-operation clears outputs without a clock edge
    clr_in();
    ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_mem_to_reg = 1; ex_rd = 5'd7;
    ex_alu_src = 1; ex_rd1 = 32'h1234; ex_rd2 = 32'h99; ex_imm = 32'd1;
    tick();
    chk("pre_arst_res", mem_alu_result, 32'h1235);
    #2;
    reset_n = 0;
    #1;
    chk_zero("arst");
    reset_n = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage RV32I pipeline. It sits directly downstream of the ID/EX register and consumes that register's outputs. It performs operand forwarding, ALU control decode, ALU evaluation, branch compare and branch-target computation. Results are captured in an internal EX/MEM register that feeds the memory stage, and branch redirects are issued from that register.

## Interface
Parameters: none (XLEN fixed at 32).

Ports, all active-high unless noted:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  hold the EX/MEM register
- flush  in  1  load a bubble into the EX/MEM register
- ex_valid  in  1  ID/EX entry holds a real instruction
- ex_pc, ex_rd1, ex_rd2, ex_imm  in  32 each  PC, register reads, immediate
- ex_rs1, ex_rs2, ex_rd  in  5 each  register indices
- ex_funct3  in  3  instruction funct3
- ex_funct7b5  in  1  instruction bit 30
- ex_alu_op  in  2  00 add, 01 branch compare, 10 funct decode, 11 pass immediate (LUI)
- ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  in  1 each  control bits
- wb_we  in  1  writeback stage writes a register
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback data
- mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write  out  1 each  registered control
- mem_alu_result, mem_store_data  out  32 each  registered result and store data
- mem_rd  out  5  registered destination
- branch_taken  out  1  redirect fetch, registered
- branch_target  out  32  redirect PC, registered

## Operation
**Forwarding**, evaluated independently for rs1 and rs2:
- MEM source: mem_valid & mem_reg_write & mem_rd≠0 & mem_rd==rs. Forwards mem_alu_result.
- Otherwise WB source: wb_we & wb_rd≠0 & wb_rd==rs. Forwards wb_data.
- Otherwise the ID/EX value is used.
- MEM has priority over WB.
- A load in MEM is never forwarded. The upstream hazard unit guarantees that no dependent instruction is in EX in that case.

**Operands**
- a = forwarded rs1.
- b = ex_alu_src ? ex_imm : forwarded rs2.
- Store data = forwarded rs2.

**ALU** (results mod 2^32, shift amount b[4:0]):
- alu_op 00: a+b.
- alu_op 11: ex_imm.
- alu_op 01: a−b.
- alu_op 10, by funct3:
  - 000: sub if funct7b5 & !alu_src, else add
  - 001: sll
  - 010: slt, signed
  - 011: sltu
  - 100: xor
  - 101: sra if funct7b5, else srl
  - 110: or
  - 111: and

**Branch condition** (alu_op 01), by funct3:
- 000: a==b
- 001: a≠b
- 100: a<b signed
- 101: a≥b signed
- 110: a<b unsigned
- 111: a≥b unsigned
- Other funct3 values: not taken.

**Branch target**: ex_pc + ex_imm, wrapping mod 2^32.

**EX/MEM register**, per rising edge, first matching rule applies:
1. squash = flush | branch_taken: mem_valid and all mem_* control bits load 0, branch_taken loads 0, data fields are don't-care. The instruction in EX is wrong-path when branch_taken=1.
2. stall: every register holds its value.
3. Otherwise every register loads its EX value:
   - mem_valid ← ex_valid.
   - Control bits ← ex_* & ex_valid.
   - branch_taken ← ex_valid & ex_branch & condition.
   - branch_target ← target.

## Timing
- Reset (async assert, release synchronous to clock): every output is 0.
- Latency: 1 cycle from ID/EX outputs to mem_* and branch_taken.
- branch_taken is high for exactly one cycle per taken branch. Upstream must flush IF/ID and ID/EX in that same cycle.
- Squash overrides stall, so a held taken branch cannot re-assert.
- Forwarding is combinational from the registered MEM fields and the WB inputs; there is no added cycle.
- x0 is never forwarded, and a result with rd=0 never affects any operand.

## Test plan
- **Reset**: drive reset_n=0 mid-operation with non-zero inputs → all outputs read 0 immediately, without waiting for a clock edge.
- **R-type sub with MEM forwarding**:
  - Stimulus: instruction A writes x5=7. Next cycle, B is sub rd=x6, rs1=x5 (stale ex_rd1=0), rs2 with ex_rd2=3, alu_op=10, funct3=000, funct7b5=1.
  - Required: mem_alu_result=4.
  - Also with wb_rd=x5, wb_data=9 present: MEM still wins, result stays 4.
- **sra/srl**: a=0x80000010, b=0x24 (shift amount 4):
  - funct3=101, funct7b5=1 → result 0xF8000001.
  - funct3=101, funct7b5=0 → result 0x08000001.
- **Taken blt**:
  - Stimulus: a=−1, b=1, funct3=100, pc=0x100, imm=0xFFFFFFF0.
  - Required: branch_taken=1 and branch_target=0xF0 for one cycle.
  - The following EX instruction is squashed: mem_valid=0 and mem_reg_write=0.
- **Stall/flush priority**:
  - stall=1 for 3 cycles → all outputs hold their values.
  - stall=1 together with flush=1 → bubble loaded: mem_valid=0, all control bits 0.
- **x0 / invalid entry**:
  - A writes rd=0 with value 0xDEAD. The dependent instruction reads rs1=0 → operand is ex_rd1, not 0xDEAD.
  - ex_valid=0 with ex_reg_write=1 → mem_reg_write=0.
